ring_rr_arbiter: RTL and testbench
==================================

Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Priority is tracked by a one-hot rotating ring pointer, which behaves like a ring counter advanced one position past each completed grant.
- A grant is held while its requester keeps requesting, up to MAX_HOLD cycles; at MAX_HOLD the grant is forcibly rotated to the next requester.
- The block sits between multiple datapath masters and a single shared unit, for example a shared counter or register bank.

Parameters:
- N, 4: number of requesters; ≥2.
- MAX_HOLD, 8: maximum consecutive grant cycles per ownership; ≥1.
- CW, $clog2(MAX_HOLD+1): width of hold_cnt; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- clr  input  1  synchronous active-high reset.
- req  input  N  level request per requester; bit i = requester i.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  high when gnt is non-zero.
- ptr  output  N  one-hot ring pointer; the highest-priority position for the next arbitration.
- hold_cnt  output  CW  number of cycles the current gnt has been asserted; 1 in the first granted cycle.
- timeout  output  1  one-cycle pulse on the edge a grant is ended by MAX_HOLD expiry.

Behaviour:
- Reset:
  - clr is sampled on the rising edge of clk and dominates all other inputs.
  - The next state is gnt=0, gnt_valid=0, ptr=one-hot bit 0, hold_cnt=0, timeout=0, state=IDLE.
  - A clr asserted mid-grant drops the grant at that same edge; there is no drain.
- States: IDLE and GRANT.
- Selection function sel(mask, p): the first set bit of mask, scanning circularly from position p upward and wrapping N-1→0.
- IDLE:
  - If req≠0: gnt <= sel(req, ptr), hold_cnt <= 1, go to GRANT. Latency is one cycle from req sampled to gnt visible.
  - If req=0: remain in IDLE; gnt stays 0 and ptr is unchanged.
- GRANT, with the current owner g, is handled in three cases.
- Case 1, continue: req[g]=1 and hold_cnt<MAX_HOLD.
  - Keep gnt unchanged.
  - hold_cnt <= hold_cnt+1.
- Case 2, release: req[g]=0.
  - ptr <= rotl(gnt).
  - If (req & ~gnt)≠0: gnt <= sel(req & ~gnt, rotl(gnt)) and hold_cnt <= 1. This is back-to-back handover with no idle cycle.
  - Otherwise: gnt <= 0, hold_cnt <= 0, go to IDLE.
- Case 3, timeout: req[g]=1 and hold_cnt==MAX_HOLD.
  - timeout <= 1 for one cycle.
  - ptr <= rotl(gnt).
  - If (req & ~gnt)≠0: grant sel(req & ~gnt, rotl(gnt)).
  - Otherwise: re-grant g.
  - In both outcomes hold_cnt <= 1.
- Rotation and one-hot rules:
  - rotl wraps: the bit N-1 owner yields a pointer at bit 0.
  - gnt is never multi-hot.
  - ptr is always exactly one-hot.
- Request changes:
  - Requests rising or falling on non-owner bits during GRANT have no effect until the next arbitration point (release or timeout).
  - If a request is dropped and a new one raised in the same cycle as a release, the new request is eligible at that edge.
- gnt_valid is a registered copy of |gnt, updated on the same edge as gnt.
- With MAX_HOLD=1, every granted cycle is a timeout cycle, so ownership rotates every cycle among the active requesters.

Test Plan:
1. Reset: clr=1 for 2 cycles with req=1111 -> gnt=0000, gnt_valid=0, ptr=0001, hold_cnt=0. Release clr -> gnt=0001 on the next edge.
2. Single requester from IDLE: req=0100 -> gnt=0100 and hold_cnt=1 one cycle later. Drop req -> gnt=0000 and ptr=1000 on the next edge.
3. All requesting, each owner drops its req after 2 granted cycles and re-raises it 1 cycle later -> grant order 0001,0010,0100,1000,0001 with no idle cycles between grants.
4. Timeout with MAX_HOLD=8, req=0011 held continuously:
   - gnt=0001 for 8 cycles with hold_cnt counting 1..8.
   - timeout pulses once, then gnt=0010 for 8 cycles.
   - Ownership then alternates between the two requesters.
5. Sole-requester timeout, req=1000 held:
   - gnt stays 1000 throughout.
   - timeout pulses every 8 cycles and hold_cnt wraps 8→1.
   - ptr becomes 0001 after the first expiry.
6. Pointer wrap and clr mid-grant:
   - With ptr=1000 and req=0101 -> gnt=0001.
   - Assert clr during that grant -> gnt=0000, ptr=0001 and timeout=0 on that same edge.

Source files
------------

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with a one-hot ring pointer and bounded grant hold
// Ports: clk, clr (sync active-high reset), req[N] level requests,
//        gnt[N] registered one-hot grant, gnt_valid = |gnt, ptr[N] one-hot priority pointer,
//        hold_cnt[CW] cycles the current grant has been held, timeout pulse on MAX_HOLD expiry
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [N-1:0]  ptr,
    output logic [CW-1:0] hold_cnt,
    output logic          timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [N-1:0] gnt_n, ptr_n, others, rot;
    logic [CW-1:0] hold_n;
    logic to_n, own, hand;
    // first set bit of m at or above one-hot p, else wrap to the lowest set bit
    function automatic logic [N-1:0] sel(input logic [N-1:0] m, input logic [N-1:0] p);
        logic [N-1:0] hi;
        hi = m & ~(p - N'(1));
        return (|hi) ? (hi & (~hi + N'(1))) : (m & (~m + N'(1)));
    endfunction
    always_comb begin
        rot     = {gnt[N-2:0], gnt[N-1]};
        others  = req & ~gnt;
        own     = |(req & gnt);
        hand    = |others;
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        to_n    = 1'b0;
        if (state == IDLE) begin
            if (|req) begin
                gnt_n   = sel(req, ptr);
                hold_n  = CW'(1);
                state_n = GRANT;
            end
        end else if (own && hold_cnt < CW'(MAX_HOLD)) begin
            hold_n = hold_cnt + CW'(1);
        end else begin
            // arbitration point: release (owner dropped) or expiry (owner still requesting)
            ptr_n   = rot;
            to_n    = own;
            gnt_n   = hand ? sel(others, rot) : (own ? gnt : '0);
            hold_n  = (hand || own) ? CW'(1) : '0;
            state_n = (hand || own) ? GRANT : IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= N'(1);
            hold_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_valid <= |gnt_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            timeout   <= to_n;
        end
    end
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter: directed scoreboard bench for ring_rr_arbiter (N=4, MAX_HOLD=8)
module tb_ring_rr_arbiter;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] gnt, ptr, hold_cnt;
    logic       gnt_valid, timeout;
    int         ncmp = 0;
    int         nfail = 0;

    typedef struct packed {
        logic [3:0] g;
        logic       v;
        logic [3:0] p;
        logic [3:0] h;
        logic       t;
    } exp_t;
    exp_t sb[$];

    ring_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk(clk), .clr(clr), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
        .ptr(ptr), .hold_cnt(hold_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
        ncmp++;
        assert (got === want) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    // drive one cycle of inputs, push the expected post-edge state, then pop and compare
    task automatic cyc(input logic c, input logic [3:0] r, input logic [3:0] eg,
                       input logic [3:0] ep, input int eh, input logic et);
        exp_t e;
        clr = c;
        req = r;
        sb.push_back('{g: eg, v: |eg, p: ep, h: 4'(eh), t: et});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt", gnt, e.g);
        chk("gnt_valid", {3'b0, gnt_valid}, {3'b0, e.v});
        chk("ptr", ptr, e.p);
        chk("hold_cnt", hold_cnt, e.h);
        chk("timeout", {3'b0, timeout}, {3'b0, e.t});
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset dominates active requests
        cyc(1, 4'b1111, 4'b0000, 4'b0001, 0, 0);
        cyc(1, 4'b1111, 4'b0000, 4'b0001, 0, 0);
        cyc(0, 4'b1111, 4'b0001, 4'b0001, 1, 0);
        cyc(0, 4'b0000, 4'b0000, 4'b0010, 0, 0);
        // single requester from idle, release moves pointer past it
        cyc(0, 4'b0100, 4'b0100, 4'b0010, 1, 0);
        cyc(0, 4'b0000, 4'b0000, 4'b1000, 0, 0);
        // all requesting, each owner drops after two cycles: back-to-back handover
        cyc(1, 4'b0000, 4'b0000, 4'b0001, 0, 0);
        cyc(0, 4'b1111, 4'b0001, 4'b0001, 1, 0);
        cyc(0, 4'b1111, 4'b0001, 4'b0001, 2, 0);
        cyc(0, 4'b1110, 4'b0010, 4'b0010, 1, 0);
        cyc(0, 4'b1111, 4'b0010, 4'b0010, 2, 0);
        cyc(0, 4'b1101, 4'b0100, 4'b0100, 1, 0);
        cyc(0, 4'b1111, 4'b0100, 4'b0100, 2, 0);
        cyc(0, 4'b1011, 4'b1000, 4'b1000, 1, 0);
        cyc(0, 4'b1111, 4'b1000, 4'b1000, 2, 0);
        cyc(0, 4'b0111, 4'b0001, 4'b0001, 1, 0);
        cyc(0, 4'b0000, 4'b0000, 4'b0010, 0, 0);
        // two requesters held: forced rotation at MAX_HOLD
        cyc(1, 4'b0000, 4'b0000, 4'b0001, 0, 0);
        for (int i = 1; i <= 8; i++) cyc(0, 4'b0011, 4'b0001, 4'b0001, i, 0);
        cyc(0, 4'b0011, 4'b0010, 4'b0010, 1, 1);
        for (int i = 2; i <= 8; i++) cyc(0, 4'b0011, 4'b0010, 4'b0010, i, 0);
        cyc(0, 4'b0011, 4'b0001, 4'b0100, 1, 1);
        cyc(0, 4'b0000, 4'b0000, 4'b0010, 0, 0);
        // sole requester at bit N-1: re-grant on expiry, pointer wraps to bit 0
        for (int i = 1; i <= 8; i++) cyc(0, 4'b1000, 4'b1000, 4'b0010, i, 0);
        cyc(0, 4'b1000, 4'b1000, 4'b0001, 1, 1);
        for (int i = 2; i <= 8; i++) cyc(0, 4'b1000, 4'b1000, 4'b0001, i, 0);
        cyc(0, 4'b1000, 4'b1000, 4'b0001, 1, 1);
        cyc(0, 4'b1000, 4'b1000, 4'b0001, 2, 0);
        cyc(0, 4'b0000, 4'b0000, 4'b0001, 0, 0);
        // pointer at bit 3 wraps the search to bit 0, then clr mid-grant
        cyc(0, 4'b0100, 4'b0100, 4'b0001, 1, 0);
        cyc(0, 4'b0000, 4'b0000, 4'b1000, 0, 0);
        cyc(0, 4'b0101, 4'b0001, 4'b1000, 1, 0);
        cyc(1, 4'b0101, 4'b0000, 4'b0001, 0, 0);
        cyc(0, 4'b0000, 4'b0000, 4'b0001, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
